// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared phase encoding, request record and opcode decode for the nibble bus master
package bus_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    localparam logic       OP_FETCH  = 1'b0;
    localparam logic       OP_INJECT = 1'b1;

    localparam logic [3:0] SRC_OPR   = 4'h2;
    localparam logic [3:0] IO_OPR    = 4'hE;
    localparam logic [7:0] WR_FIRST  = 8'hE0;
    localparam logic [7:0] WR_LAST   = 8'hE7;
    localparam logic [7:0] RD_FIRST  = 8'hE8;
    localparam logic [7:0] RD_LAST   = 8'hEF;

    typedef struct packed {
        logic        op;
        logic [11:0] addr;
        logic [7:0]  instr;
        logic [7:0]  wdata;
        logic [1:0]  bank;
    } req_t;

    // SRC is any opcode in the 2x group with the low bit set
    function automatic logic is_src(input logic [7:0] instr);
        return (instr[7:4] == SRC_OPR) && instr[0];
    endfunction

    function automatic logic is_write(input logic [7:0] instr);
        return (instr >= WR_FIRST) && (instr <= WR_LAST);
    endfunction

    function automatic logic is_read(input logic [7:0] instr);
        return (instr >= RD_FIRST) && (instr <= RD_LAST);
    endfunction

endpackage

// File: rtl/bus_phase_ctr.sv
// rtl/bus_phase_ctr.sv - free-running eight-phase counter with the X3 sync marker
module bus_phase_ctr
    import bus_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    output phase_t phase,
    output logic   sync
);

    phase_t phase_q;
    phase_t phase_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= PH_X3;
        end else begin
            phase_q <= phase_d;
        end
    end

    // X3 wraps to A1 through natural 3-bit overflow
    always_comb begin
        phase_d = phase_t'(phase_q + 3'd1);
    end

    always_comb begin
        phase = phase_q;
        sync  = (phase_q == PH_X3);
    end

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - accepts one request per bus cycle in X3 and runs it over the next eight phases
module bus_master
    import bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [11:0] req_addr,
    input  logic [7:0]  req_instr,
    input  logic [7:0]  req_wdata,
    input  logic [1:0]  req_bank,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    output logic        sync,
    output logic        rom_cmd,
    output logic [3:0]  ram_cmd_n
);

    phase_t     phase;
    req_t       cur;
    logic       active;
    logic [3:0] opr;
    logic [3:0] opa;
    logic [3:0] rd_nib;
    logic       inj;
    logic       inj_src;
    logic       inj_io;
    logic       inj_wr;
    logic       inj_rd;
    logic       cmd_on;

    bus_phase_ctr u_phase_ctr (
        .clock (clock),
        .reset (reset),
        .phase (phase),
        .sync  (sync)
    );

    assign req_ready = (phase == PH_X3);

    assign inj     = (cur.op == OP_INJECT);
    assign inj_src = inj && is_src(cur.instr);
    assign inj_io  = inj && (cur.instr[7:4] == IO_OPR);
    assign inj_wr  = inj && is_write(cur.instr);
    assign inj_rd  = inj && is_read(cur.instr);

    // X3 both closes the running cycle and opens the next, so acceptance overwrites cur
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cur    <= '0;
            opr    <= 4'h0;
            opa    <= 4'h0;
            rd_nib <= 4'h0;
        end else begin
            if (phase == PH_X3) begin
                active <= req_valid;
                if (req_valid) begin
                    cur <= '{op: req_op, addr: req_addr, instr: req_instr,
                             wdata: req_wdata, bank: req_bank};
                end
            end
            if (active) begin
                case (phase)
                    PH_M1:   opr <= inj ? cur.instr[7:4] : data_i;
                    PH_M2:   opa <= inj ? cur.instr[3:0] : data_i;
                    PH_X2:   if (inj_rd) rd_nib <= data_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        data_en = 1'b0;
        data_o  = 4'h0;
        cmd_on  = 1'b0;
        if (active) begin
            case (phase)
                PH_A1: begin
                    data_en = 1'b1;
                    data_o  = cur.addr[3:0];
                end
                PH_A2: begin
                    data_en = 1'b1;
                    data_o  = cur.addr[7:4];
                end
                PH_A3: begin
                    data_en = 1'b1;
                    data_o  = cur.addr[11:8];
                    cmd_on  = 1'b1;
                end
                PH_M1: begin
                    data_en = inj;
                    data_o  = inj ? cur.instr[7:4] : 4'h0;
                end
                PH_M2: begin
                    data_en = inj;
                    data_o  = inj ? cur.instr[3:0] : 4'h0;
                    cmd_on  = inj_io;
                end
                PH_X2: begin
                    if (inj_src) begin
                        data_en = 1'b1;
                        data_o  = cur.wdata[7:4];
                        cmd_on  = 1'b1;
                    end else if (inj_wr) begin
                        data_en = 1'b1;
                        data_o  = cur.wdata[3:0];
                    end
                end
                PH_X3: begin
                    if (inj_src) begin
                        data_en = 1'b1;
                        data_o  = cur.wdata[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_cmd    = cmd_on;
    assign ram_cmd_n  = cmd_on ? ~(4'b0001 << cur.bank) : 4'hF;
    assign resp_valid = active && (phase == PH_X3);

    always_comb begin
        resp_data = 8'h00;
        if (resp_valid) begin
            if (!inj) begin
                resp_data = {opr, opa};
            end else if (inj_rd) begin
                resp_data = {4'h0, rd_nib};
            end
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - self-checking bench: bus peripheral model, response model and per-cycle pin checks
module tb_bus_master;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_op = 1'b0;
    logic [11:0] req_addr = 12'h000;
    logic [7:0]  req_instr = 8'h00;
    logic [7:0]  req_wdata = 8'h00;
    logic [1:0]  req_bank = 2'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [3:0]  data_i;
    logic [3:0]  data_o;
    logic        data_en;
    logic        sync;
    logic        rom_cmd;
    logic [3:0]  ram_cmd_n;

    always #5 clock = ~clock;

    bus_master dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_instr  (req_instr),
        .req_wdata  (req_wdata),
        .req_bank   (req_bank),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .data_i     (data_i),
        .data_o     (data_o),
        .data_en    (data_en),
        .sync       (sync),
        .rom_cmd    (rom_cmd),
        .ram_cmd_n  (ram_cmd_n)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [3:0] init_nib(input int b, input int a);
        return 4'(b * 7 + a * 3 + 1);
    endfunction

    // Phase index 0..7 = A1..X3 and the request the current cycle is running
    int          bph;
    logic        cur_act;
    logic        cur_op;
    logic [11:0] cur_addr;
    logic [7:0]  cur_instr;
    logic [7:0]  cur_wdata;
    logic [1:0]  cur_bank;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bph     <= 7;
            cur_act <= 1'b0;
        end else begin
            bph <= (bph + 1) % 8;
            if (bph == 7) begin
                cur_act   <= req_valid;
                cur_op    <= req_op;
                cur_addr  <= req_addr;
                cur_instr <= req_instr;
                cur_wdata <= req_wdata;
                cur_bank  <= req_bank;
            end
        end
    end

    // Bus peripherals: ROM chips and RAM banks with per-bank SRC register
    logic [7:0]  rom [4096];
    logic [3:0]  env_ram [4][256];
    logic [7:0]  env_src [4];
    logic [11:0] addr_lat;
    logic        rom_sel;
    logic        io_cyc;
    logic        src_pend;
    logic [3:0]  src_hi;
    logic        bank_ok;
    logic [1:0]  bank_idx;
    logic [3:0]  env_drive;

    initial begin : env
        for (int b = 0; b < 4; b++) begin
            env_src[b] = 8'h00;
            for (int a = 0; a < 256; a++) env_ram[b][a] = init_nib(b, a);
        end
        addr_lat = 12'h000; rom_sel = 1'b0; io_cyc = 1'b0; src_pend = 1'b0;
        src_hi = 4'h0; bank_ok = 1'b0; bank_idx = 2'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                rom_sel = 1'b0; io_cyc = 1'b0; src_pend = 1'b0; bank_ok = 1'b0;
            end else begin
                case (bph)
                    0: if (data_en) addr_lat[3:0] = data_o;
                    1: if (data_en) addr_lat[7:4] = data_o;
                    2: begin
                        if (data_en) addr_lat[11:8] = data_o;
                        rom_sel = rom_cmd;
                        io_cyc  = 1'b0;
                        bank_ok = 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            if (!ram_cmd_n[i]) begin
                                bank_ok  = 1'b1;
                                bank_idx = 2'(i);
                            end
                        end
                    end
                    4: if (rom_cmd) io_cyc = 1'b1;
                    6: begin
                        if (rom_cmd) begin
                            src_hi   = data_o;
                            src_pend = 1'b1;
                        end else if (io_cyc && data_en && bank_ok) begin
                            env_ram[bank_idx][env_src[bank_idx]] = data_o;
                        end
                    end
                    7: begin
                        if (src_pend && bank_ok) env_src[bank_idx] = {src_hi, data_o};
                        src_pend = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        env_drive = 4'h0;
        if (rom_sel && bph == 3)                    env_drive = rom[addr_lat][7:4];
        else if (rom_sel && bph == 4)               env_drive = rom[addr_lat][3:0];
        else if (io_cyc && bank_ok && bph == 6)     env_drive = env_ram[bank_idx][env_src[bank_idx]];
    end

    assign data_i = data_en ? data_o : env_drive;

    // Response model: what each request must return, from the opcode rules alone
    logic [3:0] m_ram [4][256];
    logic [7:0] m_src [4];
    logic [7:0] exp_q [$];

    initial begin : cmp
        logic       e_en;
        logic [3:0] e_o;
        logic       e_cmd;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       c_src;
        logic       c_io;
        forever begin
            @(negedge clock);
            if (chk_en && !reset) begin
                e_en  = 1'b0;
                e_o   = 4'h0;
                e_cmd = 1'b0;
                c_src = cur_op && cur_instr[7:4] == 4'h2 && cur_instr[0];
                c_io  = cur_op && cur_instr[7:4] == 4'hE;
                if (cur_act) begin
                    case (bph)
                        0: begin e_en = 1'b1; e_o = cur_addr[3:0]; end
                        1: begin e_en = 1'b1; e_o = cur_addr[7:4]; end
                        2: begin e_en = 1'b1; e_o = cur_addr[11:8]; e_cmd = 1'b1; end
                        3: begin e_en = cur_op; e_o = cur_instr[7:4]; end
                        4: begin e_en = cur_op; e_o = cur_instr[3:0]; e_cmd = c_io; end
                        6: begin
                            if (c_src) begin
                                e_en = 1'b1; e_o = cur_wdata[7:4]; e_cmd = 1'b1;
                            end else if (c_io && !cur_instr[3]) begin
                                e_en = 1'b1; e_o = cur_wdata[3:0];
                            end
                        end
                        7: if (c_src) begin e_en = 1'b1; e_o = cur_wdata[3:0]; end
                        default: ;
                    endcase
                end
                chk("sync", 32'(sync), 32'(bph == 7));
                chk("req_ready", 32'(req_ready), 32'(bph == 7));
                chk("data_en", 32'(data_en), 32'(e_en));
                if (e_en) chk("data_o", 32'(data_o), 32'(e_o));
                chk("rom_cmd", 32'(rom_cmd), 32'(e_cmd));
                chk("ram_cmd_n", 32'(ram_cmd_n),
                    32'(e_cmd ? 4'(~(4'b0001 << cur_bank)) : 4'hF));
                e_rv = cur_act && bph == 7;
                chk("resp_valid", 32'(resp_valid), 32'(e_rv));
                if (e_rv) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_queue_empty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e_rd = exp_q.pop_front();
                        chk("resp_data", 32'(resp_data), 32'(e_rd));
                    end
                end
            end
        end
    end

    task automatic wait_x3(output int waited);
        waited = 0;
        while (bph != 7 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (bph != 7) chk("wait_x3_timeout", 32'(waited), 32'd0);
    endtask

    task automatic issue(input logic op, input logic [11:0] addr, input logic [7:0] instr,
                         input logic [7:0] wd, input logic [1:0] bank);
        logic [7:0] e;
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_instr = instr; req_wdata = wd; req_bank = bank;
        @(posedge clock);
        if (!op)                                   e = rom[addr];
        else if (instr[7:4] == 4'h2 && instr[0]) begin m_src[bank] = wd; e = 8'h00; end
        else if (instr[7:4] == 4'hE && !instr[3]) begin m_ram[bank][m_src[bank]] = wd[3:0]; e = 8'h00; end
        else if (instr[7:4] == 4'hE)               e = {4'h0, m_ram[bank][m_src[bank]]};
        else                                       e = 8'h00;
        exp_q.push_back(e);
        #1;
        req_valid = 1'b0;
        req_op    = 1'($urandom_range(0, 1));
        req_addr  = 12'($urandom);
        req_instr = 8'($urandom);
        req_wdata = 8'($urandom);
        req_bank  = 2'($urandom_range(0, 3));
    endtask

    logic [31:0] tr_o;
    logic [31:0] tr_ram;
    logic [7:0]  tr_en;
    logic [7:0]  tr_rom;
    logic [7:0]  tr_rv;
    logic [7:0]  tr_rdy;
    logic [7:0]  tr_rd;

    task automatic run_one(input logic op, input logic [11:0] addr, input logic [7:0] instr,
                           input logic [7:0] wd, input logic [1:0] bank, output int waited);
        wait_x3(waited);
        issue(op, addr, instr, wd, bank);
        tr_rd = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            tr_o[k*4 +: 4]   = data_o;
            tr_ram[k*4 +: 4] = ram_cmd_n;
            tr_en[k]  = data_en;
            tr_rom[k] = rom_cmd;
            tr_rv[k]  = resp_valid;
            tr_rdy[k] = req_ready;
            if (resp_valid) tr_rd = resp_data;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sync"},       32'(sync),       32'd1);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"},  32'(resp_data),  32'h00);
        chk({tag, "_data_o"},     32'(data_o),     32'h0);
        chk({tag, "_data_en"},    32'(data_en),    32'd0);
        chk({tag, "_rom_cmd"},    32'(rom_cmd),    32'd0);
        chk({tag, "_ram_cmd_n"},  32'(ram_cmd_n),  32'hF);
    endtask

    initial begin : main
        int         w;
        int         rv_seen;
        logic [7:0] sbits;
        logic [7:0] ins;
        logic [7:0] wd;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h123] = 8'hD5;
        for (int b = 0; b < 4; b++) begin
            m_src[b] = 8'h00;
            for (int a = 0; a < 256; a++) m_ram[b][a] = init_nib(b, a);
        end

        #1 reset = 1'b1;
        #2 check_reset_vals("por");
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("first_sync", 32'(sync), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            sbits[k] = sync;
        end
        chk("sync_pattern", 32'(sbits), 32'h80);

        run_one(1'b0, 12'h123, 8'h00, 8'h00, 2'd1, w);
        chk("fetch_wait", 32'(w), 32'd0);
        chk("fetch_addr_nibbles", 32'(tr_o[11:0]), 32'h123);
        chk("fetch_en", 32'(tr_en), 32'h07);
        chk("fetch_rom_cmd", 32'(tr_rom), 32'h04);
        chk("fetch_ram_cmd_n", tr_ram, 32'hFFFF_FDFF);
        chk("fetch_latency", 32'(tr_rv), 32'h80);
        chk("fetch_resp", 32'(tr_rd), 32'hD5);

        run_one(1'b1, 12'hF00, 8'h21, 8'h4C, 2'd0, w);
        chk("src_bus_m1", 32'(tr_o[15:12]), 32'h2);
        chk("src_bus_m2", 32'(tr_o[19:16]), 32'h1);
        chk("src_bus_x2", 32'(tr_o[27:24]), 32'h4);
        chk("src_bus_x3", 32'(tr_o[31:28]), 32'hC);
        chk("src_en", 32'(tr_en), 32'hDF);
        chk("src_ram_cmd_n", tr_ram, 32'hFEFF_FEFF);
        chk("src_rom_cmd", 32'(tr_rom), 32'h44);
        chk("src_resp", 32'(tr_rd), 32'h00);
        chk("b2b_ready_with_resp", 32'({tr_rdy[7], tr_rv[7]}), 32'h3);

        run_one(1'b1, 12'hF00, 8'hE0, 8'h07, 2'd0, w);
        chk("b2b_no_gap", 32'(w), 32'd0);
        chk("b2b_addr", 32'(tr_o[11:0]), 32'hF00);
        chk("wr_rom_cmd", 32'(tr_rom), 32'h14);
        chk("wr_bus_x2", 32'(tr_o[27:24]), 32'h7);

        run_one(1'b1, 12'hF00, 8'hE9, 8'h00, 2'd0, w);
        chk("rd_en", 32'(tr_en), 32'h1F);
        chk("rd_resp", 32'(tr_rd), 32'h07);
        chk("ram_0x4c", 32'(env_ram[0][8'h4C]), 32'h7);

        // Abort an INJECT read during M2
        wait_x3(w);
        issue(1'b1, 12'hF00, 8'hE9, 8'h00, 2'd0);
        for (int k = 0; k < 5; k++) @(negedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        #1 check_reset_vals("abort");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (resp_valid) rv_seen++;
        end
        chk("abort_no_resp", 32'(rv_seen), 32'd0);

        for (int i = 0; i < 80; i++) begin
            wait_x3(w);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: begin
                        ins = {4'h2, 3'($urandom_range(0, 7)), 1'b1};
                        wd  = {4'h4, 2'b00, 2'($urandom_range(0, 3))};
                    end
                    1: begin ins = {5'b11100, 3'($urandom_range(0, 7))}; wd = 8'($urandom); end
                    2: begin ins = {5'b11101, 3'($urandom_range(0, 7))}; wd = 8'($urandom); end
                    default: begin ins = 8'($urandom); wd = 8'($urandom); end
                endcase
                issue(1'($urandom_range(0, 1)), 12'($urandom), ins, wd, 2'($urandom_range(0, 3)));
            end else begin
                @(posedge clock);
                #1;
            end
        end
        wait_x3(w);
        for (int k = 0; k < 9; k++) @(negedge clock);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
